cordic_phase_gen: RTL
=====================

CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 SHALL have parameter TMO_CYC, default 32, the WAIT-state watchdog limit in cycles.
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  run enable, level.
REQ-005 SHALL have port load  input  1  phase preload strobe.
REQ-006 SHALL have port phase_init  input  25  preload phase, unsigned degrees*2^16.
REQ-007 SHALL have port fcw  input  25  phase step per sample, unsigned degrees*2^16.
REQ-008 SHALL have port cordic_done  input  1  one-cycle completion pulse from the sin/cos CORDIC stage.
REQ-009 SHALL have port angle  output  25  folded angle in [0, 90 deg]*2^16, registered.
REQ-010 SHALL have port vld  output  1  one-cycle issue strobe to the CORDIC stage.
REQ-011 SHALL have port quad  output  2  quadrant of the issued phase, registered.
REQ-012 SHALL have port sin_neg  output  1  sign fix for the downstream sine, equal to quad[1].
REQ-013 SHALL have port cos_neg  output  1  sign fix for the downstream cosine, equal to quad[1]^quad[0].
REQ-014 SHALL have port busy  output  1  high in ISSUE and WAIT.
REQ-015 SHALL have port timeout  output  1  sticky watchdog flag.

Function
REQ-016 SHALL use these constants: D90=5898240, D180=11796480, D270=17694720, D360=23592960.
REQ-017 SHALL hold a 25-bit phase register, always kept in [0, D360).
REQ-018 SHALL have a three-state FSM with states IDLE, ISSUE and WAIT, where ISSUE lasts exactly one cycle.
REQ-019 SHALL go IDLE->ISSUE when en=1 and load=0; in ISSUE, vld=1 and angle/quad are updated from phase in the same cycle.
REQ-020 SHALL go ISSUE->WAIT unconditionally.
REQ-021 SHALL go WAIT->ISSUE on cordic_done when en=1, and WAIT->IDLE on cordic_done when en=0.
REQ-022 SHALL ignore cordic_done when the FSM is outside WAIT.
REQ-023 SHALL fold the phase as follows: p<D90 gives quad=0, angle=p; p<D180 gives quad=1, angle=D180-p; p<D270 gives quad=2, angle=p-D180; otherwise quad=3, angle=D360-p.
REQ-024 SHALL advance the phase in the ISSUE cycle: s=phase+fcw_r; phase<=s-D360 if s>=D360, else s.
REQ-025 SHALL compute fcw_r as fcw-D360 if fcw>=D360, else fcw; one subtraction suffices because inputs are below 720 deg.
REQ-026 SHALL, on load in IDLE, set phase<=phase_init reduced the same way as fcw, clear timeout, and stay in IDLE for that cycle.
REQ-027 SHALL ignore load in ISSUE and WAIT.
REQ-028 SHALL hold angle and quad between issues.
REQ-029 SHALL issue at most one vld per CORDIC completion, i.e. never with a request outstanding.
REQ-030 SHALL give a minimum issue spacing equal to the CORDIC turnaround plus 1 cycle.
REQ-031 SHALL, when en drops in WAIT, complete the outstanding request before returning to IDLE.
REQ-032 SHALL treat boundary values p=D90, D180 and D270 as the start of the higher quadrant; for example p=D90 gives quad=1, angle=D90.

Reset
REQ-033 SHALL, while rst_n=0, force FSM=IDLE, phase=0, angle=0, quad=0, vld=0, busy=0, timeout=0 and the watchdog count=0.
REQ-034 SHALL abandon any outstanding request on reset mid-operation, with no vld emitted after release until en is sampled high.

Configuration
REQ-035 SHALL, with CORDIC_TIMEOUT_EN defined, count WAIT cycles; reaching TMO_CYC without cordic_done SHALL set timeout and force IDLE, and the next ISSUE SHALL still follow en.
REQ-036 SHALL, without CORDIC_TIMEOUT_EN, wait in WAIT indefinitely, tie timeout to 0, and include no counter logic.

Verification
REQ-037 SHALL cover: reset, load phase_init=0, fcw=D90, en=1, done returned 19 cycles after each vld -> issues show quad 0,1,2,3,0 and angle 0, D90, 0, D90, 0.
REQ-038 SHALL cover: load phase_init=D360+100 -> phase=100; first issue gives quad=0, angle=100.
REQ-039 SHALL cover: phase 20971520 (320 deg) with fcw=3932160 (60 deg) -> next phase 1310720 (20 deg), quad=0, and the issue after the 320 deg one gives angle=1310720.
REQ-040 SHALL cover: en deasserted one cycle after vld -> exactly one more done is accepted, FSM returns to IDLE, no further vld.
REQ-041 SHALL cover: CORDIC_TIMEOUT_EN defined and no done -> timeout=1 exactly TMO_CYC cycles after entering WAIT, FSM in IDLE; a subsequent load clears timeout.
REQ-042 SHALL cover: rst_n pulsed low during WAIT -> all outputs reach their reset values asynchronously, and a stray done after release is ignored.

Source files
------------

// File: rtl/cordic_phase_gen.sv
// Phase accumulator and quadrant fold feeding a sin/cos CORDIC stage with a one-request handshake.
// Optional WAIT watchdog is compiled in when CORDIC_TIMEOUT_EN is defined.
module cordic_phase_gen #(
   parameter int TMO_CYC = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [24:0] phase_init,
   input  logic [24:0] fcw,
   input  logic        cordic_done,
   output logic [24:0] angle,
   output logic        vld,
   output logic [1:0]  quad,
   output logic        sin_neg,
   output logic        cos_neg,
   output logic        busy,
   output logic        timeout
);
   // state | meaning
   // IDLE  | stopped, phase preload accepted
   // ISSUE | one-cycle vld strobe to the CORDIC, phase advances
   // WAIT  | request outstanding, waiting for cordic_done
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam logic [24:0] D90  = 25'd5898240;
   localparam logic [24:0] D180 = 25'd11796480;
   localparam logic [24:0] D270 = 25'd17694720;
   localparam logic [24:0] D360 = 25'd23592960;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [24:0] phase;
   logic [24:0] fcw_r;
   logic [24:0] init_r;
   logic [25:0] sum;
   logic [24:0] sum_wrap;
   logic [24:0] phase_adv;
   logic [24:0] fold_angle;
   logic [1:0]  fold_quad;
   logic        tmo_hit;

   // Inputs stay below 720 deg, so one conditional subtraction normalises them.
   function automatic logic [24:0] wrap360(input logic [24:0] v);
      return (v >= D360) ? v - D360 : v;
   endfunction

   assign fcw_r  = wrap360(fcw);
   assign init_r = wrap360(phase_init);

   assign sum       = {1'b0, phase} + {1'b0, fcw_r};
   assign sum_wrap  = sum[24:0] - D360;
   assign phase_adv = (sum >= {1'b0, D360}) ? sum_wrap : sum[24:0];

   always_comb begin
      fold_angle = phase;
      fold_quad  = 2'd0;
      if (phase < D90) begin
         fold_angle = phase;
         fold_quad  = 2'd0;
      end else if (phase < D180) begin
         fold_angle = D180 - phase;
         fold_quad  = 2'd1;
      end else if (phase < D270) begin
         fold_angle = phase - D180;
         fold_quad  = 2'd2;
      end else begin
         fold_angle = D360 - phase;
         fold_quad  = 2'd3;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (en && !load) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (cordic_done)  state_nxt = en ? S_ISSUE : S_IDLE;
            else if (tmo_hit) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         phase <= '0;
         angle <= '0;
         quad  <= '0;
      end else begin
         state <= state_nxt;
         // Fold the phase being issued; the register advances during ISSUE.
         if (state_nxt == S_ISSUE) begin
            angle <= fold_angle;
            quad  <= fold_quad;
         end
         if (state == S_IDLE && load)
            phase <= init_r;
         else if (state == S_ISSUE)
            phase <= phase_adv;
      end
   end

   assign vld     = (state == S_ISSUE);
   assign busy    = (state == S_ISSUE) || (state == S_WAIT);
   assign sin_neg = quad[1];
   assign cos_neg = quad[1] ^ quad[0];

`ifdef CORDIC_TIMEOUT_EN
   localparam int CW = $clog2(TMO_CYC + 1);

   logic [CW-1:0] tmo_cnt;
   logic          tmo_flag;

   // Down-counter loaded on ISSUE; terminal count reached on the TMO_CYC-th WAIT cycle.
   assign tmo_hit = (state == S_WAIT) && (tmo_cnt == '0) && !cordic_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt  <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (state == S_ISSUE)
            tmo_cnt <= CW'(TMO_CYC - 1);
         else if (state == S_WAIT && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - CW'(1);
         if (state == S_IDLE && load)
            tmo_flag <= 1'b0;
         else if (tmo_hit)
            tmo_flag <= 1'b1;
      end
   end

   assign timeout = tmo_flag;
`else
   localparam int unused_tmo_cyc = TMO_CYC;

   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule
